// File: rtl/gerenciador_contexto.sv
// Context-switch responder: saves the outgoing PC into a per-process table,
// restores the incoming process's PC (or its start address), stalls the CPU
// for the duration and issues a one-cycle PC load to fetch.
module gerenciador_contexto #(
    parameter int unsigned NUM_PROC  = 5,
    parameter int unsigned PC_WIDTH  = 32,
    parameter logic [31:0] PC_STRIDE = 32'd256
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                troca_contexto,
    input  logic [31:0]         processo_atual,
    input  logic [PC_WIDTH-1:0] pc_processo_atual,
    output logic                cpu_parar,
    output logic                pc_carregar,
    output logic [PC_WIDTH-1:0] pc_novo,
    output logic [31:0]         processo_em_execucao,
    output logic                contexto_ack,
    output logic                erro_processo,
    output logic                pedido_perdido
);

    localparam int unsigned ID_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam int unsigned PROD_W = 64;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] SALVA   = 2'd1;
    localparam logic [1:0] CARREGA = 2'd2;
    localparam logic [1:0] RETOMA  = 2'd3;

    logic [1:0]          estado, estado_nxt;
    logic [31:0]         id_entrada, id_entrada_nxt;
    logic [PC_WIDTH-1:0] pc_saida, pc_saida_nxt;
    logic [ID_W-1:0]     id_corrente, id_corrente_nxt;
    logic [NUM_PROC-1:0] valido;
    logic [PC_WIDTH-1:0] tabela [NUM_PROC];

    logic                cpu_parar_nxt;
    logic                pc_carregar_nxt;
    logic                contexto_ack_nxt;
    logic [PC_WIDTH-1:0] pc_novo_nxt;
    logic [31:0]         processo_em_execucao_nxt;
    logic                erro_processo_nxt;
    logic                pedido_perdido_nxt;
    logic                tab_we;

    logic                id_fora_c;
    logic [ID_W-1:0]     id_idx_c;
    logic [PC_WIDTH-1:0] pc_inicial_c;

    // Incoming id decode and never-run start address (id * stride, truncated)
    always_comb begin
        id_fora_c    = (id_entrada >= 32'(NUM_PROC));
        id_idx_c     = id_entrada[ID_W-1:0];
        pc_inicial_c = PC_WIDTH'(PROD_W'(id_entrada) * PROD_W'(PC_STRIDE));
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado               <= OCIOSO;
            id_entrada           <= '0;
            pc_saida             <= '0;
            id_corrente          <= '0;
            cpu_parar            <= 1'b0;
            pc_carregar          <= 1'b0;
            contexto_ack         <= 1'b0;
            pc_novo              <= '0;
            processo_em_execucao <= '0;
            erro_processo        <= 1'b0;
            pedido_perdido       <= 1'b0;
        end else begin
            estado               <= estado_nxt;
            id_entrada           <= id_entrada_nxt;
            pc_saida             <= pc_saida_nxt;
            id_corrente          <= id_corrente_nxt;
            cpu_parar            <= cpu_parar_nxt;
            pc_carregar          <= pc_carregar_nxt;
            contexto_ack         <= contexto_ack_nxt;
            pc_novo              <= pc_novo_nxt;
            processo_em_execucao <= processo_em_execucao_nxt;
            erro_processo        <= erro_processo_nxt;
            pedido_perdido       <= pedido_perdido_nxt;
        end
    end

    // Next-state and next-output logic for the switch sequence
    always_comb begin
        estado_nxt               = estado;
        id_entrada_nxt           = id_entrada;
        pc_saida_nxt             = pc_saida;
        id_corrente_nxt          = id_corrente;
        cpu_parar_nxt            = cpu_parar;
        pc_carregar_nxt          = 1'b0;
        contexto_ack_nxt         = 1'b0;
        pc_novo_nxt              = pc_novo;
        processo_em_execucao_nxt = processo_em_execucao;
        erro_processo_nxt        = erro_processo;
        pedido_perdido_nxt       = pedido_perdido;
        tab_we                   = 1'b0;

        case (estado)
            OCIOSO: begin
                if (troca_contexto) begin
                    id_entrada_nxt = processo_atual;
                    pc_saida_nxt   = pc_processo_atual;
                    cpu_parar_nxt  = 1'b1;
                    estado_nxt     = SALVA;
                end
            end
            SALVA: begin
                tab_we     = 1'b1;
                estado_nxt = CARREGA;
            end
            CARREGA: begin
                if (id_fora_c) begin
                    // Unknown process: hand the CPU back to the outgoing one
                    erro_processo_nxt = 1'b1;
                    pc_novo_nxt       = pc_saida;
                end else begin
                    pc_novo_nxt              = valido[id_idx_c] ? tabela[id_idx_c] : pc_inicial_c;
                    id_corrente_nxt          = id_idx_c;
                    processo_em_execucao_nxt = id_entrada;
                end
                pc_carregar_nxt  = 1'b1;
                contexto_ack_nxt = 1'b1;
                estado_nxt       = RETOMA;
            end
            RETOMA: begin
                cpu_parar_nxt = 1'b0;
                estado_nxt    = OCIOSO;
            end
            default: begin
                estado_nxt = OCIOSO;
            end
        endcase

        // Requests are single-cycle pulses; one arriving mid-switch is dropped
        if (troca_contexto && (estado != OCIOSO)) begin
            pedido_perdido_nxt = 1'b1;
        end
    end

    // Context table valid bits, cleared on reset so every process restarts fresh
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valido <= '0;
        end else if (tab_we) begin
            valido[id_corrente] <= 1'b1;
        end
    end

    // Context table storage; contents are qualified by the valid bits
    always_ff @(posedge clock) begin
        if (tab_we) begin
            tabela[id_corrente] <= pc_saida;
        end
    end

endmodule
